// File: rtl/gpu2d_bg_pkg.sv
// Shared BG-pipeline definitions: tile geometry, colour-index width, row buffer and fetch request types.
package gpu2d_bg_pkg;

  localparam int COL_IDX_W  = 6;
  localparam int ROW_PIX    = 16;
  localparam int TILE_ROWS  = 16;
  localparam int TILE_IDX_W = 8;
  localparam int ROW_W      = $clog2(TILE_ROWS);
  localparam int POS_W      = $clog2(ROW_PIX);
  localparam int ADDR_W     = TILE_IDX_W + ROW_W;

  typedef logic [COL_IDX_W-1:0] col_idx_t;
  typedef col_idx_t [ROW_PIX-1:0] row_buf_t;

  typedef struct packed {
    logic [TILE_IDX_W-1:0] tile_idx;
    logic [ROW_W-1:0]      row;
    logic                  hflip;
    logic [POS_W-1:0]      x_start;
  } fetch_req_t;

  // Row lane shown at emit position pos; mirrored rows read from the far end.
  function automatic logic [POS_W-1:0] pix_lane(input logic hflip, input logic [POS_W-1:0] pos);
    return hflip ? (POS_W'(ROW_PIX - 1) - pos) : pos;
  endfunction

endpackage

// File: rtl/bg_row_buf.sv
// One buffered tile row plus its emit metadata (h-flip, start column) and a valid flag.
module bg_row_buf
  import gpu2d_bg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  row_buf_t         data_in,
  input  logic             hflip_in,
  input  logic [POS_W-1:0] x_start_in,
  output logic             valid,
  output row_buf_t         data,
  output logic             hflip,
  output logic [POS_W-1:0] x_start
);

  logic             valid_reg;
  row_buf_t         data_reg;
  logic             hflip_reg;
  logic [POS_W-1:0] x_start_reg;

  // A load in the same cycle as a clear refills the slot that is being freed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      hflip_reg   <= 1'b0;
      x_start_reg <= '0;
    end else if (load) begin
      valid_reg   <= 1'b1;
      data_reg    <= data_in;
      hflip_reg   <= hflip_in;
      x_start_reg <= x_start_in;
    end else if (clear) begin
      valid_reg   <= 1'b0;
    end
  end

  assign valid   = valid_reg;
  assign data    = data_reg;
  assign hflip   = hflip_reg;
  assign x_start = x_start_reg;

endmodule

// File: rtl/bg_tile_row_fetcher.sv
// Fetches one tile row from BG tile RAM per request and streams its pixels; a pending row buffer
// lets the next fetch complete while the active row is still being emitted.
module bg_tile_row_fetcher
  import gpu2d_bg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_flush,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic [TILE_IDX_W-1:0] io_req_tileIdx,
  input  logic [ROW_W-1:0]      io_req_row,
  input  logic                  io_req_hflip,
  input  logic [POS_W-1:0]      io_req_xStart,
  output logic                  io_rdEn,
  output logic [ADDR_W-1:0]     io_rdAddr,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_0,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_1,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_2,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_3,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_4,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_5,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_6,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_7,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_8,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_9,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_10,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_11,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_12,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_13,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_14,
  input  logic [COL_IDX_W-1:0]  io_rdData_colIdxVec_15,
  output logic                  io_pix_valid,
  input  logic                  io_pix_ready,
  output logic [COL_IDX_W-1:0]  io_pix_colIdx,
  output logic                  io_pix_transparent,
  output logic                  io_pix_last
);

  fetch_req_t       req;
  row_buf_t         rd_row;
  logic             in_flight_reg;
  logic             flight_hflip_reg;
  logic [POS_W-1:0] flight_x_start_reg;
  logic [POS_W-1:0] pos_reg, pos_next;

  logic             accept, capture, capture_direct, promote;
  logic             xfer, last_xfer, act_free, at_last;
  logic             pend_valid, pend_hflip, pend_load, pend_clear;
  logic [POS_W-1:0] pend_x_start;
  row_buf_t         pend_data;
  logic             act_valid, act_hflip, act_load, act_clear;
  logic [POS_W-1:0] act_x_start;
  row_buf_t         act_data;
  row_buf_t         act_data_in;
  logic             act_hflip_in;
  logic [POS_W-1:0] act_x_start_in;

  assign req = '{tile_idx: io_req_tileIdx, row: io_req_row, hflip: io_req_hflip, x_start: io_req_xStart};
  assign rd_row = {io_rdData_colIdxVec_15, io_rdData_colIdxVec_14, io_rdData_colIdxVec_13,
                   io_rdData_colIdxVec_12, io_rdData_colIdxVec_11, io_rdData_colIdxVec_10,
                   io_rdData_colIdxVec_9,  io_rdData_colIdxVec_8,  io_rdData_colIdxVec_7,
                   io_rdData_colIdxVec_6,  io_rdData_colIdxVec_5,  io_rdData_colIdxVec_4,
                   io_rdData_colIdxVec_3,  io_rdData_colIdxVec_2,  io_rdData_colIdxVec_1,
                   io_rdData_colIdxVec_0};

  // Only one row may be in flight or pending, so a returning read always has a free slot.
  assign io_req_ready = reset && !in_flight_reg && !pend_valid && !io_flush;
  assign accept       = io_req_valid && io_req_ready;
  assign io_rdEn      = accept;
  assign io_rdAddr    = accept ? {req.tile_idx, req.row} : '0;

  assign at_last   = (pos_reg == POS_W'(ROW_PIX - 1));
  assign xfer      = act_valid && io_pix_ready;
  assign last_xfer = xfer && at_last;
  assign act_free  = !act_valid || last_xfer;

  // Returning data skips the pending slot when the emitter can take it now (2-cycle latency).
  assign capture        = in_flight_reg && !io_flush;
  assign capture_direct = capture && act_free && !pend_valid;
  assign promote        = pend_valid && act_free && !io_flush;

  assign pend_load  = capture && !capture_direct;
  assign pend_clear = io_flush || promote;
  assign act_load   = capture_direct || promote;
  assign act_clear  = io_flush || last_xfer;

  assign act_data_in    = promote ? pend_data    : rd_row;
  assign act_hflip_in   = promote ? pend_hflip   : flight_hflip_reg;
  assign act_x_start_in = promote ? pend_x_start : flight_x_start_reg;

  bg_row_buf u_pend (
    .clk        (clk),
    .reset      (reset),
    .load       (pend_load),
    .clear      (pend_clear),
    .data_in    (rd_row),
    .hflip_in   (flight_hflip_reg),
    .x_start_in (flight_x_start_reg),
    .valid      (pend_valid),
    .data       (pend_data),
    .hflip      (pend_hflip),
    .x_start    (pend_x_start)
  );

  bg_row_buf u_act (
    .clk        (clk),
    .reset      (reset),
    .load       (act_load),
    .clear      (act_clear),
    .data_in    (act_data_in),
    .hflip_in   (act_hflip_in),
    .x_start_in (act_x_start_in),
    .valid      (act_valid),
    .data       (act_data),
    .hflip      (act_hflip),
    .x_start    (act_x_start)
  );

  always_comb begin
    pos_next = pos_reg;
    if (act_load) begin
      pos_next = act_x_start_in;
    end else if (xfer && !at_last) begin
      pos_next = pos_reg + 1'b1;
    end
  end

  // in_flight lasts exactly the RAM latency; a flush drops it because capture is masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight_reg      <= 1'b0;
      flight_hflip_reg   <= 1'b0;
      flight_x_start_reg <= '0;
      pos_reg            <= '0;
    end else begin
      in_flight_reg <= accept;
      if (accept) begin
        flight_hflip_reg   <= req.hflip;
        flight_x_start_reg <= req.x_start;
      end
      pos_reg <= pos_next;
    end
  end

  assign io_pix_valid       = act_valid;
  assign io_pix_colIdx      = act_valid ? act_data[pix_lane(act_hflip, pos_reg)] : '0;
  assign io_pix_transparent = act_valid && (io_pix_colIdx == '0);
  assign io_pix_last        = act_valid && at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(capture && pend_valid));
    end
  end

endmodule

// File: tb/tb_bg_tile_row_fetcher.sv
// Bench for bg_tile_row_fetcher: vector table, directed corner sequences and random traffic vs a pixel-queue model.
module tb_bg_tile_row_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_flush = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_hflip = 1'b0;
  logic        io_pix_ready = 1'b0;
  logic [7:0]  io_req_tileIdx = '0;
  logic [3:0]  io_req_row = '0;
  logic [3:0]  io_req_xStart = '0;
  logic        io_req_ready, io_rdEn, io_pix_valid, io_pix_transparent, io_pix_last;
  logic [11:0] io_rdAddr;
  logic [5:0]  io_pix_colIdx;
  logic [5:0]  rd_lane [16];
  logic [5:0]  ram_mem [4096][16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Tile RAM model: 1-cycle read latency, output holds when not enabled.
  always @(posedge clk) begin
    if (io_rdEn) begin
      for (int n = 0; n < 16; n++) rd_lane[n] <= ram_mem[io_rdAddr][n];
    end
  end

  bg_tile_row_fetcher dut (
    .clk(clk), .reset(reset), .io_flush(io_flush),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_tileIdx(io_req_tileIdx), .io_req_row(io_req_row),
    .io_req_hflip(io_req_hflip), .io_req_xStart(io_req_xStart),
    .io_rdEn(io_rdEn), .io_rdAddr(io_rdAddr),
    .io_rdData_colIdxVec_0(rd_lane[0]),   .io_rdData_colIdxVec_1(rd_lane[1]),
    .io_rdData_colIdxVec_2(rd_lane[2]),   .io_rdData_colIdxVec_3(rd_lane[3]),
    .io_rdData_colIdxVec_4(rd_lane[4]),   .io_rdData_colIdxVec_5(rd_lane[5]),
    .io_rdData_colIdxVec_6(rd_lane[6]),   .io_rdData_colIdxVec_7(rd_lane[7]),
    .io_rdData_colIdxVec_8(rd_lane[8]),   .io_rdData_colIdxVec_9(rd_lane[9]),
    .io_rdData_colIdxVec_10(rd_lane[10]), .io_rdData_colIdxVec_11(rd_lane[11]),
    .io_rdData_colIdxVec_12(rd_lane[12]), .io_rdData_colIdxVec_13(rd_lane[13]),
    .io_rdData_colIdxVec_14(rd_lane[14]), .io_rdData_colIdxVec_15(rd_lane[15]),
    .io_pix_valid(io_pix_valid), .io_pix_ready(io_pix_ready),
    .io_pix_colIdx(io_pix_colIdx), .io_pix_transparent(io_pix_transparent),
    .io_pix_last(io_pix_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request appends its ROW_PIX-xStart pixels; a flush discards all.
  typedef struct packed { logic [5:0] col; logic last; } exp_t;
  exp_t exp_q[$];
  logic prev_stall = 1'b0;
  logic [5:0] prev_col = '0;
  logic prev_last = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(io_pix_valid), 32'd1);
        check("hold_col", 32'(io_pix_colIdx), 32'(prev_col));
        check("hold_last", 32'(io_pix_last), 32'(prev_last));
      end
      check("rd_en", 32'(io_rdEn), 32'(io_req_valid && io_req_ready));
      if (io_rdEn) check("rd_addr", 32'(io_rdAddr), 32'({io_req_tileIdx, io_req_row}));
      if (io_flush) check("flush_ready", 32'(io_req_ready), 32'd0);
      if (io_pix_valid && io_pix_ready) begin
        check("pix_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_col", 32'(io_pix_colIdx), 32'(e.col));
          check("pix_last", 32'(io_pix_last), 32'(e.last));
          check("pix_transp", 32'(io_pix_transparent), 32'(e.col == 6'd0));
        end
      end
      prev_stall = io_pix_valid && !io_pix_ready && !io_flush;
      prev_col   = io_pix_colIdx;
      prev_last  = io_pix_last;
      if (io_flush) exp_q.delete();
      if (io_req_valid && io_req_ready) begin
        for (int k = int'(io_req_xStart); k < 16; k++) begin
          int lane;
          lane = io_req_hflip ? 15 - k : k;
          exp_q.push_back('{col: ram_mem[{io_req_tileIdx, io_req_row}][lane], last: (k == 15)});
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  tile;
    logic [3:0]  row;
    logic        hflip;
    logic [3:0]  xs;
    logic [11:0] addr;
    int          count;
    logic [5:0]  first_v;
    logic [5:0]  last_v;
  } vec_t;

  // Single row with pix_ready=1: checks accept cycle, 2-cycle latency, contiguity, first/last value.
  task automatic run_row(input vec_t v);
    int first_cyc, last_cyc, n_pix;
    logic [5:0] first_v, last_v;
    bit done;
    first_cyc = -1; last_cyc = -1; n_pix = 0; done = 0; first_v = '0; last_v = '0;
    @(negedge clk);
    io_pix_ready = 1'b1;
    io_req_valid = 1'b1; io_req_tileIdx = v.tile; io_req_row = v.row;
    io_req_hflip = v.hflip; io_req_xStart = v.xs;
    #2;
    check("row_req_ready", 32'(io_req_ready), 32'd1);
    check("row_rd_en", 32'(io_rdEn), 32'd1);
    check("row_rd_addr", 32'(io_rdAddr), 32'(v.addr));
    for (int cyc = 1; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      io_req_valid = 1'b0;
      #2;
      if (io_pix_valid) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_v = io_pix_colIdx; end
        n_pix++;
        if (io_pix_last) begin last_v = io_pix_colIdx; last_cyc = cyc; done = 1; end
      end
    end
    check("row_done", 32'(done), 32'd1);
    check("row_latency", 32'(first_cyc), 32'd2);
    check("row_count", 32'(n_pix), 32'(v.count));
    check("row_contig", 32'(last_cyc - first_cyc + 1), 32'(v.count));
    check("row_first", 32'(first_v), 32'(v.first_v));
    check("row_last", 32'(last_v), 32'(v.last_v));
    $display("row tile=%0d row=%0d hflip=%0d xs=%0d pixels=%0d first=%0d last=%0d",
             v.tile, v.row, v.hflip, v.xs, n_pix, first_v, last_v);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v_after;
    int acc, npix, gaps, lasts, b_acc_cyc, first_last_cyc, ntr, ntransp, nvalid;
    bit started;

    for (int a = 0; a < 4096; a++)
      for (int n = 0; n < 16; n++) ram_mem[a][n] = 6'(a * 37 + n * 11 + (a >> 5));
    for (int n = 0; n < 16; n++) begin
      rd_lane[n] = '0;
      ram_mem[12'h035][n] = 6'(n + 1);
      ram_mem[12'h042][n] = 6'(33 + n);
      ram_mem[12'h051][n] = (n == 7) ? 6'd0 : 6'(n + 1);
      ram_mem[12'h060][n] = 6'(20 + n);
    end
    vecs[0] = '{8'd3, 4'd5, 1'b0, 4'd0,  12'h035, 16, 6'd1,  6'd16};
    vecs[1] = '{8'd3, 4'd5, 1'b1, 4'd4,  12'h035, 12, 6'd12, 6'd1};
    vecs[2] = '{8'd3, 4'd5, 1'b0, 4'd15, 12'h035, 1,  6'd16, 6'd16};
    vecs[3] = '{8'd3, 4'd5, 1'b1, 4'd15, 12'h035, 1,  6'd1,  6'd1};
    vecs[4] = '{8'd3, 4'd5, 1'b0, 4'd8,  12'h035, 8,  6'd9,  6'd16};
    v_after = '{8'd6, 4'd0, 1'b0, 4'd0,  12'h060, 16, 6'd20, 6'd35};

    repeat (3) @(negedge clk);
    #2;
    check("rst_pix_valid", 32'(io_pix_valid), 32'd0);
    check("rst_pix_col", 32'(io_pix_colIdx), 32'd0);
    check("rst_pix_last", 32'(io_pix_last), 32'd0);
    check("rst_transp", 32'(io_pix_transparent), 32'd0);
    check("rst_rd_en", 32'(io_rdEn), 32'd0);
    check("rst_req_ready", 32'(io_req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    io_pix_ready = 1'b1;
    #2;
    check("post_rst_ready", 32'(io_req_ready), 32'd1);

    foreach (vecs[i]) run_row(vecs[i]);

    // Back-to-back rows: second fetch overlaps emission, no bubble at the row boundary.
    acc = 0; npix = 0; gaps = 0; lasts = 0; started = 0; b_acc_cyc = -1; first_last_cyc = -1;
    for (int c = 0; c < 60 && lasts < 2; c++) begin
      @(negedge clk);
      io_req_valid = (acc < 2);
      io_req_tileIdx = (acc == 0) ? 8'd3 : 8'd4;
      io_req_row = (acc == 0) ? 4'd5 : 4'd2;
      io_req_hflip = 1'b0; io_req_xStart = 4'd0;
      #2;
      if (io_req_valid && io_req_ready) begin acc++; if (acc == 2) b_acc_cyc = c; end
      if (io_pix_valid) begin
        started = 1; npix++;
        if (io_pix_last) begin lasts++; if (lasts == 1) first_last_cyc = c; end
      end else if (started) gaps++;
    end
    check("b2b_lasts", 32'(lasts), 32'd2);
    check("b2b_pixels", 32'(npix), 32'd32);
    check("b2b_gaps", 32'(gaps), 32'd0);
    check("b2b_overlap", 32'(b_acc_cyc >= 0 && b_acc_cyc < first_last_cyc), 32'd1);
    $display("b2b pixels=%0d gaps=%0d second_accept=%0d first_last=%0d", npix, gaps, b_acc_cyc, first_last_cyc);

    // Toggling pix_ready with a transparent lane 7.
    @(negedge clk);
    io_req_valid = 1'b1; io_req_tileIdx = 8'd5; io_req_row = 4'd1; io_req_hflip = 1'b0; io_req_xStart = 4'd0;
    #2;
    check("stall_accept", 32'(io_req_ready), 32'd1);
    ntr = 0; ntransp = 0;
    for (int c = 0; c < 80 && ntr < 16; c++) begin
      @(negedge clk);
      io_req_valid = 1'b0;
      io_pix_ready = c[0];
      #2;
      if (io_pix_valid && io_pix_ready) begin ntr++; if (io_pix_transparent) ntransp++; end
    end
    check("stall_count", 32'(ntr), 32'd16);
    check("stall_transp", 32'(ntransp), 32'd1);
    $display("stall transfers=%0d transparent=%0d", ntr, ntransp);

    // Flush while the read is in flight.
    @(negedge clk);
    io_pix_ready = 1'b1;
    io_req_valid = 1'b1; io_req_tileIdx = 8'd3; io_req_row = 4'd5; io_req_hflip = 1'b0; io_req_xStart = 4'd0;
    #2;
    check("flush_accept", 32'(io_req_ready), 32'd1);
    @(negedge clk);
    io_flush = 1'b1;
    #2;
    check("flush_no_ready", 32'(io_req_ready), 32'd0);
    check("flush_no_rden", 32'(io_rdEn), 32'd0);
    @(negedge clk);
    io_flush = 1'b0; io_req_valid = 1'b0;
    nvalid = 0;
    repeat (10) begin
      #2;
      if (io_pix_valid) nvalid++;
      @(negedge clk);
    end
    check("flush_quiet", 32'(nvalid), 32'd0);
    $display("flush valid_cycles_after=%0d", nvalid);
    run_row(v_after);

    // Reset mid-row with the pending buffer full.
    acc = 0; ntr = 0;
    for (int c = 0; c < 60 && ntr < 9; c++) begin
      @(negedge clk);
      io_req_valid = (acc < 2);
      io_req_tileIdx = (acc == 0) ? 8'd3 : 8'd4;
      io_req_row = (acc == 0) ? 4'd5 : 4'd2;
      #2;
      if (io_req_valid && io_req_ready) acc++;
      if (io_pix_valid && io_pix_ready) ntr++;
    end
    check("mid_accepts", 32'(acc), 32'd2);
    check("mid_transfers", 32'(ntr), 32'd9);
    @(negedge clk);
    io_req_valid = 1'b1; io_req_tileIdx = 8'd7; io_req_row = 4'd3;
    #2;
    check("mid_valid", 32'(io_pix_valid), 32'd1);
    check("mid_pend_full", 32'(io_req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("arst_pix_valid", 32'(io_pix_valid), 32'd0);
    check("arst_pix_col", 32'(io_pix_colIdx), 32'd0);
    check("arst_pix_last", 32'(io_pix_last), 32'd0);
    check("arst_transp", 32'(io_pix_transparent), 32'd0);
    check("arst_rd_en", 32'(io_rdEn), 32'd0);
    check("arst_rd_addr", 32'(io_rdAddr), 32'd0);
    check("arst_ready", 32'(io_req_ready), 32'd0);
    @(negedge clk);
    io_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("arst_release_ready", 32'(io_req_ready), 32'd1);
    $display("reset mid-row at transfer %0d, released", ntr);
    run_row(vecs[0]);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      io_req_valid   = ($urandom_range(0, 1) == 1);
      io_req_tileIdx = 8'($urandom);
      io_req_row     = 4'($urandom);
      io_req_hflip   = 1'($urandom_range(0, 1));
      io_req_xStart  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      io_pix_ready   = ($urandom_range(0, 9) < 7);
      io_flush       = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    io_req_valid = 1'b0; io_flush = 1'b0; io_pix_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    #2;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(io_pix_valid), 32'd0);
    $display("random phase done, model queue=%0d", exp_q.size());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
